mem_bus_arbiter_rr: RTL
=======================

# mem_bus_arbiter_rr

N-port round-robin arbiter and multiplexer for the shared memory bus. It sits between the fetch, data-cache and other bus masters (bottoms) and the single memory port (top). It generalises the two-port fixed-priority mux to `NUM_PORTS` masters with fair rotation, registered grant, back-to-back handover and an optional forced-release timeout.

## Interface
- `NUM_PORTS`, 2: number of bottom masters (2..8)
- `DATA_WIDTH`, 64: width of `req`/`resp`
- `TAG_WIDTH`, 13: width of `reqtag`
- `MAX_HOLD`, 64: grant cycles before forced release (used only with timeout enabled)
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `bot_bid` in NUM_PORTS: per-port bus request/hold
- `bot_reqcyc` in NUM_PORTS: per-port request valid
- `bot_req` in NUM_PORTS*DATA_WIDTH: request data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `bot_reqtag` in NUM_PORTS*TAG_WIDTH: request tag, same packing
- `bot_respack` in NUM_PORTS: response accepted
- `bot_reqack` out NUM_PORTS: request accepted
- `bot_respcyc` out NUM_PORTS: response valid
- `bot_resp` out NUM_PORTS*DATA_WIDTH: response data
- `top_bid`, `top_reqcyc`, `top_respack` out 1: to memory
- `top_req` out DATA_WIDTH; `top_reqtag` out TAG_WIDTH: to memory
- `top_reqack`, `top_respcyc` in 1; `top_resp` in DATA_WIDTH: from memory
- `grant` out NUM_PORTS: one-hot owner, all-zero when IDLE
- `owner` out $clog2(NUM_PORTS): index of the current owner, 0 when IDLE

## Operation
- States: IDLE, BUSY. Registered: `state`, `owner`, `last_owner` (rotation pointer), `hold_cnt`, `txn_open`.
- IDLE, any `bot_bid` set: choose the first bidder scanning from `last_owner+1` modulo NUM_PORTS, then go to BUSY.
- BUSY: ownership holds while `bot_bid[owner]`=1.
- Owner drops bid: `last_owner` is set to `owner`.
  - If another port bids in the same cycle, grant passes directly to the next round-robin bidder in that same edge, with no IDLE cycle.
  - Otherwise go to IDLE.
- Routing uses only the registered `grant`.
  - `top_*` request signals and `top_respack` come from the owner.
  - The owner's `bot_reqack`, `bot_respcyc` and `bot_resp` mirror the top inputs.
  - Non-owners see all zeros. In IDLE, all `top_*` outputs are 0.
- `txn_open`:
  - Set on `top_reqcyc & top_reqack`.
  - Cleared at the edge following a cycle where `top_respcyc`=0 after a cycle where it was 1.
- Reset mid-transaction: all state clears at the edge and outputs are 0 the next cycle. Memory-side recovery is not this block's responsibility.
- Reset values: `grant`=0, `owner`=0, `last_owner`=NUM_PORTS-1 (so port 0 wins first), all `top_*`/`bot_*` outputs 0, `hold_cnt`=0, `txn_open`=0.

## Timing
- Grant latency: 1 cycle. `bot_bid[i]` sampled at edge t gives `grant[i]`=1 and routing active in cycle t+1.
- Release latency: 1 cycle. The owner drops bid in cycle t and grant changes at edge t+1.
- Request path latency: 0 cycles, combinational from the owner's inputs.
- Response path latency: 0 cycles, combinational from the top inputs.
- `hold_cnt` is cleared on each grant change and increments in each BUSY cycle, saturating at MAX_HOLD.
- Owner keeps `bid` with no competitor: ownership is kept indefinitely, regardless of the timeout.

## Configuration
- `MEMBUS_ARB_TIMEOUT_EN` defined: in BUSY, when all three conditions below hold, ownership is forcibly rotated to the next round-robin bidder at the next edge, even if the owner still bids.
  - `hold_cnt`>=MAX_HOLD
  - another port bids
  - `txn_open`=0
  - The preempted port must re-win through rotation.
- Not defined: no `hold_cnt`, no forced release. Ownership ends only when the owner drops `bid`.

## Test plan
- Reset, then port 2 bids alone (NUM_PORTS=4) -> `grant`=4'b0100 one cycle later. Top mirrors port 2; ports 0, 1 and 3 outputs stay 0.
- All 4 ports bid continuously; each owner drops bid for 1 cycle after one transaction -> grant order is 0,1,2,3,0 with no IDLE cycles between handovers.
- Port 0 owns; `top_respcyc` pulses for 8 beats with resp=0xA5.. -> only `bot_respcyc[0]` toggles and `bot_resp[1..3]` stay 0.
- Reset asserted during BUSY with `top_respcyc`=1 -> next cycle `grant`=0 and all outputs are 0. After release, port 0 wins first.
- TIMEOUT_EN, MAX_HOLD=4: port 1 holds bid with no open transaction while port 3 bids -> `grant` switches to port 3 after 4 BUSY cycles. With `txn_open`=1, no switch happens until the response ends.
- Without TIMEOUT_EN, same stimulus -> port 1 keeps the grant for 100 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter_rr.sv
// mem_bus_arbiter_rr: N-port round-robin arbiter and multiplexer for the
// shared memory bus. Bottom masters bid for ownership; the registered grant
// steers the owner's request to the single memory port and the memory's
// response back to the owner only. Handover between bidders happens in a
// single edge with no IDLE gap.
// Optional feature: define MEMBUS_ARB_TIMEOUT_EN to enable forced release of
// an owner that has held the bus for MAX_HOLD cycles while another port waits
// and no transaction is outstanding.
module mem_bus_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int MAX_HOLD   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            bot_bid,
  input  logic [NUM_PORTS-1:0]            bot_reqcyc,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] bot_req,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]  bot_reqtag,
  input  logic [NUM_PORTS-1:0]            bot_respack,
  output logic [NUM_PORTS-1:0]            bot_reqack,
  output logic [NUM_PORTS-1:0]            bot_respcyc,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] bot_resp,
  output logic                            top_bid,
  output logic                            top_reqcyc,
  output logic                            top_respack,
  output logic [DATA_WIDTH-1:0]           top_req,
  output logic [TAG_WIDTH-1:0]            top_reqtag,
  input  logic                            top_reqack,
  input  logic                            top_respcyc,
  input  logic [DATA_WIDTH-1:0]           top_resp,
  output logic [NUM_PORTS-1:0]            grant,
  output logic [$clog2(NUM_PORTS)-1:0]    owner
);

  localparam int OW = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [OW:0]          pick_idle, pick_busy;
  logic                 force_rel;

  // First bidder scanning from ptr+1 around the ring; MSB flags "found".
  function automatic logic [OW:0] rr_pick(input logic [OW-1:0]        ptr,
                                          input logic [NUM_PORTS-1:0] bids);
    logic          found;
    logic [OW-1:0] idx;
    logic [OW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = OW'((int'(ptr) + i) % NUM_PORTS);
      if (!found && bids[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // From IDLE the scan starts after the rotation pointer; on handover the
  // current owner is masked so the scan naturally starts after it.
  assign pick_idle = rr_pick(last_q, bot_bid);
  assign pick_busy = rr_pick(owner_q, bot_bid & ~grant_q);

`ifdef MEMBUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          txn_open_q;
  logic          resp_prev_q;

  // Preempt only when the hold budget is spent, someone is waiting and no
  // response is still owed to the current owner.
  assign force_rel = (hold_q >= HW'(MAX_HOLD)) && pick_busy[OW] && !txn_open_q;

  // Hold counter: restarts on every grant change, saturates while BUSY.
  always_comb begin
    hold_d = hold_q;
    if (grant_d != grant_q)                              hold_d = '0;
    else if (state_q == BUSY && hold_q < HW'(MAX_HOLD))  hold_d = hold_q + 1'b1;
  end

  // Hold counter and open-transaction tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      txn_open_q  <= 1'b0;
      resp_prev_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      resp_prev_q <= top_respcyc;
      // A transaction closes once the response burst has ended (1 then 0).
      if (top_reqcyc && top_reqack)        txn_open_q <= 1'b1;
      else if (resp_prev_q && !top_respcyc) txn_open_q <= 1'b0;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // Next-state logic: arbitration in IDLE, release/handover in BUSY.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[OW]) begin
          state_d = BUSY;
          owner_d = pick_idle[OW-1:0];
          grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idle[OW-1:0];
        end
      end
      BUSY: begin
        if (!bot_bid[owner_q] || force_rel) begin
          last_d = owner_q;
          if (pick_busy[OW]) begin
            owner_d = pick_busy[OW-1:0];
            grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_busy[OW-1:0];
          end else begin
            state_d = IDLE;
            owner_d = '0;
            grant_d = '0;
          end
        end
      end
    endcase
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_PORTS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Routing steered purely by the registered one-hot grant.
  always_comb begin
    top_bid     = 1'b0;
    top_reqcyc  = 1'b0;
    top_respack = 1'b0;
    top_req     = '0;
    top_reqtag  = '0;
    bot_reqack  = '0;
    bot_respcyc = '0;
    bot_resp    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        top_bid     = top_bid     | bot_bid[i];
        top_reqcyc  = top_reqcyc  | bot_reqcyc[i];
        top_respack = top_respack | bot_respack[i];
        top_req     = top_req     | bot_req[i*DATA_WIDTH +: DATA_WIDTH];
        top_reqtag  = top_reqtag  | bot_reqtag[i*TAG_WIDTH +: TAG_WIDTH];
        bot_reqack[i]  = top_reqack;
        bot_respcyc[i] = top_respcyc;
        bot_resp[i*DATA_WIDTH +: DATA_WIDTH] = top_resp;
      end
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;

endmodule
